// File: rtl/clk_rate_ctrl_if.sv
// Control/status bundle between the rate front end and the divider rate controller.
// Signal names mirror the controller's documented port names.
interface clk_rate_ctrl_if;
   logic        EN;
   logic [3:0]  RATE_SEL;
   logic        RATE_REQ;
   logic [32:0] MAX_VAL;
   logic [3:0]  CUR_SEL;
   logic        TICK;
   logic        RATE_ACK;
   logic        BUSY;

   modport master (
      output EN, RATE_SEL, RATE_REQ,
      input  MAX_VAL, CUR_SEL, TICK, RATE_ACK, BUSY
   );

   modport slave (
      input  EN, RATE_SEL, RATE_REQ,
      output MAX_VAL, CUR_SEL, TICK, RATE_ACK, BUSY
   );
endinterface

// File: rtl/clk_rate_ctrl.sv
// Divider rate controller: holds the active selection and the terminal count, and defers
// rate changes to a period boundary so the divided clock never sees a runt or stretched period.
module clk_rate_ctrl #(
   parameter logic [32:0] BASE_MAX  = 33'd50_000_000,
   parameter logic [3:0]  RESET_SEL = 4'd1
) (
   input  logic           CLK,
   input  logic           RST,
   clk_rate_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PEND = 2'd1,
      ST_STOP = 2'd2
   } state_e;

   state_e      state_q,    state_d;
   logic [3:0]  cur_sel_q,  cur_sel_d;
   logic [3:0]  pend_sel_q, pend_sel_d;
   logic [32:0] max_val_q,  max_val_d;
   logic [32:0] cnt_q,      cnt_d;
   logic        ack_q,      ack_d;
   logic        busy_q,     busy_d;
   logic        tick;
   logic        apply;

   // Selection 0 means stopped; larger selections halve the count, floored at 1.
   function automatic logic [32:0] max_of(input logic [3:0] sel);
      logic [32:0] v;
      if (sel == 4'd0) begin
         return 33'd0;
      end
      v = BASE_MAX >> (sel - 4'd1);
      return (v == 33'd0) ? 33'd1 : v;
   endfunction

   assign tick  = bus.EN && (state_q != ST_STOP) && (cnt_q == max_val_q);
   assign apply = (state_q == ST_PEND) && tick;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d    = state_q;
      cur_sel_d  = cur_sel_q;
      pend_sel_d = pend_sel_q;
      max_val_d  = max_val_q;
      cnt_d      = cnt_q;
      ack_d      = 1'b0;
      busy_d     = busy_q;

      case (state_q)
         ST_STOP: begin
            cnt_d = 33'd0;
            if (bus.RATE_REQ) begin
               ack_d = 1'b1;
               if (bus.RATE_SEL != 4'd0) begin
                  cur_sel_d = bus.RATE_SEL;
                  max_val_d = max_of(bus.RATE_SEL);
                  state_d   = ST_RUN;
               end
            end
         end
         default: begin
            if (bus.EN) begin
               cnt_d = tick ? 33'd0 : cnt_q + 33'd1;
            end
            if (apply) begin
               cur_sel_d = pend_sel_q;
               max_val_d = max_of(pend_sel_q);
               cnt_d     = 33'd0;
               ack_d     = 1'b1;
               busy_d    = 1'b0;
               state_d   = (pend_sel_q == 4'd0) ? ST_STOP : ST_RUN;
            end
            // A request landing on the applying tick is judged against the newly applied selection.
            if (bus.RATE_REQ) begin
               if ((state_q == ST_PEND) && !apply) begin
                  pend_sel_d = bus.RATE_SEL;
               end else if (bus.RATE_SEL == cur_sel_d) begin
                  ack_d = 1'b1;
               end else begin
                  pend_sel_d = bus.RATE_SEL;
                  busy_d     = 1'b1;
                  state_d    = ST_PEND;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (RST) begin
         state_q    <= ST_RUN;
         cur_sel_q  <= RESET_SEL;
         pend_sel_q <= 4'd0;
         max_val_q  <= max_of(RESET_SEL);
         cnt_q      <= 33'd0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_sel_q  <= cur_sel_d;
         pend_sel_q <= pend_sel_d;
         max_val_q  <= max_val_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.MAX_VAL  = max_val_q;
   assign bus.CUR_SEL  = cur_sel_q;
   assign bus.TICK     = tick;
   assign bus.RATE_ACK = ack_q;
   assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Bench for clk_rate_ctrl with BASE_MAX = 16: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed tick spacing and output values.
module tb_clk_rate_ctrl;
   localparam int BASE  = 16;
   localparam int LIMIT = 300;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   clk_rate_ctrl_if bus();

   clk_rate_ctrl #(
      .BASE_MAX (33'd16),
      .RESET_SEL(4'd1)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int ack_seen = 0;
   bit checking = 1'b0;

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Terminal count for a selection, from plain division.
   function automatic logic [32:0] tbl(input int sel);
      int v;
      if (sel == 0) return 33'd0;
      v = BASE / (1 << (sel - 1));
      return (v < 1) ? 33'd1 : 33'(v);
   endfunction

   // Model: applied selection, pending selection (-1 = none), period position, ack pulse.
   int          m_cur  = 1;
   int          m_pend = -1;
   logic [32:0] m_cnt  = 33'd0;
   bit          m_ack  = 1'b0;

   function automatic bit m_stopped();
      return (m_cur == 0) && (m_pend < 0);
   endfunction

   function automatic bit m_tick();
      return bus.EN && !m_stopped() && (m_cnt == tbl(m_cur));
   endfunction

   always @(posedge CLK) begin
      bit t;
      int sel;
      t   = m_tick();
      sel = int'(bus.RATE_SEL);
      if (RST) begin
         m_cur = 1; m_pend = -1; m_cnt = 33'd0; m_ack = 1'b0;
      end else begin
         m_ack = 1'b0;
         if (m_stopped()) begin
            m_cnt = 33'd0;
            if (bus.RATE_REQ) begin
               m_ack = 1'b1;
               if (sel != 0) m_cur = sel;
            end
         end else begin
            if (bus.EN) m_cnt = t ? 33'd0 : m_cnt + 33'd1;
            if (m_pend >= 0 && t) begin
               m_cur = m_pend; m_pend = -1; m_ack = 1'b1; m_cnt = 33'd0;
            end
            if (bus.RATE_REQ) begin
               if (m_pend >= 0)      m_pend = sel;
               else if (sel == m_cur) m_ack = 1'b1;
               else                   m_pend = sel;
            end
         end
      end
   end

   // Compare process: outputs are settled mid-cycle, well away from the rising edge.
   always @(negedge CLK) begin
      if (checking) begin
         check("model_max_val",  bus.MAX_VAL,          tbl(m_cur));
         check("model_cur_sel",  33'(bus.CUR_SEL),     33'(m_cur));
         check("model_tick",     33'(bus.TICK),        33'(m_tick()));
         check("model_rate_ack", 33'(bus.RATE_ACK),    33'(m_ack));
         check("model_busy",     33'(bus.BUSY),        33'(m_pend >= 0));
         if (bus.RATE_ACK) ack_seen++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic req(input int sel);
      bus.RATE_SEL = 4'(sel);
      bus.RATE_REQ = 1'b1;
      step(1);
      bus.RATE_REQ = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (!bus.TICK && n < LIMIT) begin
         step(1);
         n++;
      end
   endtask

   task automatic wait_next_tick(output int n);
      int k;
      step(1);
      wait_tick(k);
      n = k + 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, ack_before, ticks;
      bus.EN = 1'b1; bus.RATE_SEL = 4'd0; bus.RATE_REQ = 1'b0;
      step(1);
      checking = 1'b1;
      step(2);
      RST = 1'b0;

      // 1: reset state and base period
      check("rst_cur_sel", 33'(bus.CUR_SEL), 33'd1);
      check("rst_max_val", bus.MAX_VAL, 33'd16);
      check("rst_busy", 33'(bus.BUSY), 33'd0);
      check("rst_ack", 33'(bus.RATE_ACK), 33'd0);
      wait_tick(n);      check("first_tick_delay", 33'(n), 33'd16);
      wait_next_tick(n); check("period_sel1", 33'(n), 33'd17);

      // 2: request sel 3 at CNT=5, applied at the boundary
      step(6);
      req(3);
      check("pend_busy", 33'(bus.BUSY), 33'd1);
      check("pend_max_held", bus.MAX_VAL, 33'd16);
      wait_tick(n);      check("pend_to_boundary", 33'(n), 33'd10);
      step(1);
      check("apply3_max", bus.MAX_VAL, 33'd4);
      check("apply3_cur", 33'(bus.CUR_SEL), 33'd3);
      check("apply3_ack", 33'(bus.RATE_ACK), 33'd1);
      check("apply3_busy", 33'(bus.BUSY), 33'd0);
      wait_tick(n);      check("first_period_sel3", 33'(n + 1), 33'd5);
      wait_next_tick(n); check("period_sel3", 33'(n), 33'd5);

      // 3: last request wins, single ack
      step(1);
      ack_before = ack_seen;
      req(2);
      req(4);
      wait_tick(n);      check("pend_overwrite_boundary", 33'(n), 33'd2);
      step(1);
      check("apply4_cur", 33'(bus.CUR_SEL), 33'd4);
      check("apply4_max", bus.MAX_VAL, 33'd2);
      wait_tick(n);
      wait_next_tick(n); check("period_sel4", 33'(n), 33'd3);
      check("single_ack", 33'(ack_seen - ack_before), 33'd1);

      // 4: stop, then restart from STOP immediately
      step(1);
      req(0);
      wait_tick(n);      check("stop_boundary", 33'(n), 33'd1);
      step(1);
      check("stop_cur", 33'(bus.CUR_SEL), 33'd0);
      check("stop_max", bus.MAX_VAL, 33'd0);
      ticks = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (bus.TICK) ticks++;
      end
      check("stop_no_ticks", 33'(ticks), 33'd0);
      req(5);
      check("restart_max", bus.MAX_VAL, 33'd1);
      check("restart_cur", 33'(bus.CUR_SEL), 33'd5);
      check("restart_ack", 33'(bus.RATE_ACK), 33'd1);
      check("restart_busy", 33'(bus.BUSY), 33'd0);
      wait_tick(n);      check("restart_first_tick", 33'(n), 33'd1);
      wait_next_tick(n); check("period_sel5", 33'(n), 33'd2);

      // 5: back to sel 1, then a request coincident with a tick
      step(1);
      req(1);
      wait_tick(n);
      step(1);
      check("back_to_sel1", bus.MAX_VAL, 33'd16);
      wait_tick(n);      check("sel1_tick_again", 33'(n), 33'd16);
      req(2);
      check("coincident_not_applied", bus.MAX_VAL, 33'd16);
      check("coincident_busy", 33'(bus.BUSY), 33'd1);
      wait_tick(n);      check("coincident_wait", 33'(n), 33'd16);
      step(1);
      check("coincident_applied", bus.MAX_VAL, 33'd8);
      step(3);
      bus.EN = 1'b0;
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (bus.TICK) ticks++;
      end
      bus.EN = 1'b1;
      check("en_low_no_ticks", 33'(ticks), 33'd0);
      wait_tick(n);      check("en_freeze_resume", 33'(n), 33'd5);

      // 6: reset while a request is pending
      step(1);
      ack_before = ack_seen;
      req(3);
      check("pre_rst_busy", 33'(bus.BUSY), 33'd1);
      RST = 1'b1;
      step(1);
      check("mid_rst_cur", 33'(bus.CUR_SEL), 33'd1);
      check("mid_rst_max", bus.MAX_VAL, 33'd16);
      check("mid_rst_busy", 33'(bus.BUSY), 33'd0);
      RST = 1'b0;
      step(40);
      check("mid_rst_no_ack", 33'(ack_seen - ack_before), 33'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
